mem_ctrl: RTL

//  Request-side controller for the single-port synchronous RAM block.

---
 rtl/mem_ctrl_pkg.sv | 5 +
 rtl/mem_ctrl_stats.sv | 19 +
 rtl/mem_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM encoding and statistics counter width for mem_ctrl
package mem_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_CAPT, RESP, CLEAR} mem_ctrl_state_t;
  localparam int STATS_W = 32;
endpackage

// File: rtl/mem_ctrl_stats.sv
// mem_ctrl_stats: saturating read/write handshake counters
module mem_ctrl_stats import mem_ctrl_pkg::*; (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rd_inc,
  input  logic               wr_inc,
  output logic [STATS_W-1:0] rd_count,
  output logic [STATS_W-1:0] wr_count
);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_inc && !(&rd_count)) rd_count <= rd_count + 1'b1;
      if (wr_inc && !(&wr_count)) wr_count <= wr_count + 1'b1;
    end
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: request-side controller for a single-port sync RAM with bulk zero-fill.
// Optional rd_count/wr_count statistics ports when MEM_CTRL_STATS_EN is defined.
module mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_input,
  output logic                  mem_write_enable,
  output logic                  mem_reset,
  input  logic [DATA_WIDTH-1:0] mem_data_output
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [STATS_W-1:0]    rd_count,
  output logic [STATS_W-1:0]    wr_count
`endif
);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(RAM_DEPTH);
  mem_ctrl_state_t state, state_d;
  logic [ADDR_WIDTH:0] cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d, rdata_d;
  logic we_d;
  assign mem_reset  = !reset_n;
  assign req_ready  = reset_n && (state == IDLE) && !clear_start;
  assign clear_busy = (state == CLEAR);
  assign rsp_valid  = (state == RESP);
  always_comb begin
    state_d = state;
    addr_d  = mem_address;
    din_d   = mem_data_input;
    we_d    = 1'b0;
    cnt_d   = cnt;
    rdata_d = rsp_data;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          addr_d  = '0;
          din_d   = '0;
          we_d    = 1'b1;
          cnt_d   = 1;
        end else if (req_valid) begin
          state_d = req_write ? WRITE : RD_ISSUE;
          addr_d  = req_address;
          din_d   = req_data;
          we_d    = req_write;
        end
      end
      WRITE:    state_d = IDLE;
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
        state_d = RESP;
        rdata_d = mem_data_output;
      end
      RESP:     state_d = rsp_ready ? IDLE : RESP;
      CLEAR: begin
        // cnt is one wider than the address so the final word is written before exit
        if (cnt == LAST) state_d = IDLE;
        else begin
          addr_d = cnt[ADDR_WIDTH-1:0];
          we_d   = 1'b1;
          cnt_d  = cnt + 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      mem_address      <= '0;
      mem_data_input   <= '0;
      mem_write_enable <= 1'b0;
      rsp_data         <= '0;
      cnt              <= '0;
    end else begin
      state            <= state_d;
      mem_address      <= addr_d;
      mem_data_input   <= din_d;
      mem_write_enable <= we_d;
      rsp_data         <= rdata_d;
      cnt              <= cnt_d;
    end
  end
`ifdef MEM_CTRL_STATS_EN
  mem_ctrl_stats u_stats (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_inc   (req_valid && req_ready && !req_write),
    .wr_inc   (req_valid && req_ready && req_write),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );
`endif
endmodule
